// File: rtl/aip_router_pkg.sv
// Shared constants and helpers for the N-slave AIP router.
package aip_router_pkg;

    // Bit positions of the host strobes inside the packed strobe vector.
    localparam int STB_WRITE  = 0;
    localparam int STB_READ   = 1;
    localparam int STB_START  = 2;
    localparam int STB_COUNT  = 3;

    // Largest supported slave count; rr_pick works on vectors of this width.
    localparam int MAX_SLAVES = 16;

    // Width of a slave index. It is never narrower than one bit, even with a single slave.
    function automatic int clog2_min1(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

    // Return the first set bit of pm at or above ptr, wrapping modulo n.
    // If no bit is set, the result is 0.
    function automatic logic [3:0] rr_pick(input logic [MAX_SLAVES-1:0] pm,
                                           input logic [3:0]            ptr,
                                           input int                    n);
        logic [3:0] pick;
        logic       found;
        int         idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_SLAVES; i++) begin
            idx = int'(ptr) + i;
            if (idx >= n) idx = idx - n;
            if (i < n && !found && pm[idx[3:0]]) begin
                pick  = idx[3:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/aip_int_ctrl.sv
// Interrupt aggregation: rising-edge capture, pending/mask, round-robin id
// selection with acknowledge, plus per-slave busy tracking.
module aip_int_ctrl
    import aip_router_pkg::*;
#(
    parameter  int NUM_SLAVES = 3,
    localparam int SEL_WIDTH  = clog2_min1(NUM_SLAVES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_SLAVES-1:0] int_s,
    input  logic [NUM_SLAVES-1:0] start_fwd,
    input  logic                  mask_wr,
    input  logic [NUM_SLAVES-1:0] mask_data,
    input  logic                  int_ack,
    output logic                  int_req,
    output logic [SEL_WIDTH-1:0]  int_id,
    output logic [NUM_SLAVES-1:0] busy
);

    logic [NUM_SLAVES-1:0] int_prev_q;
    logic [NUM_SLAVES-1:0] pending_q;
    logic [NUM_SLAVES-1:0] mask_q;
    logic [SEL_WIDTH-1:0]  rr_ptr_q;

    logic [NUM_SLAVES-1:0] rise;
    logic [NUM_SLAVES-1:0] ack_clr;
    logic [NUM_SLAVES-1:0] pending_nxt;
    logic [NUM_SLAVES-1:0] mask_nxt;
    logic [SEL_WIDTH-1:0]  ptr_nxt;
    logic [SEL_WIDTH-1:0]  id_nxt;
    logic                  ack_ok;

    // Next-state of pending/mask/pointer. req and id are registered from these
    // next values, so an ack is seen in o_int_req on the following cycle.
    always_comb begin
        rise    = int_s & ~int_prev_q;
        ack_ok  = int_ack & int_req;
        ack_clr = '0;
        ptr_nxt = rr_ptr_q;
        if (ack_ok) begin
            ack_clr[int_id] = 1'b1;
            ptr_nxt = (int'(int_id) == NUM_SLAVES - 1) ? '0 : int_id + 1'b1;
        end
        // A new edge in the same cycle as an ack keeps the slave pending.
        pending_nxt = (pending_q & ~ack_clr) | rise;
        mask_nxt    = mask_wr ? mask_data : mask_q;
        id_nxt      = SEL_WIDTH'(rr_pick(MAX_SLAVES'(pending_nxt & mask_nxt),
                                         4'(ptr_nxt), NUM_SLAVES));
    end

    // Interrupt state registers and busy flags. A start sets busy and wins over a clearing edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            int_prev_q <= '0;
            pending_q  <= '0;
            mask_q     <= '1;
            rr_ptr_q   <= '0;
            int_req    <= 1'b0;
            int_id     <= '0;
            busy       <= '0;
        end else begin
            int_prev_q <= int_s;
            pending_q  <= pending_nxt;
            mask_q     <= mask_nxt;
            rr_ptr_q   <= ptr_nxt;
            int_req    <= |(pending_nxt & mask_nxt);
            int_id     <= id_nxt;
            busy       <= (busy & ~rise) | start_fwd;
        end
    end

endmodule

// File: rtl/aip_slave_router_n.sv
// Host-port to N-slave router: command decode, per-channel registers,
// read-return pipeline, and the interrupt controller instance.
//
// Strobe/valid semantics: host strobes are single-cycle pulses with no
// back-pressure. An accepted command appears on the slave strobes one cycle
// later. A read returns o_data_out together with a one-cycle o_rd_valid two
// cycles after it is issued. One read may be issued every cycle.
module aip_slave_router_n
    import aip_router_pkg::*;
#(
    parameter  int NUM_SLAVES = 3,
    parameter  int DATA_WIDTH = 32,
    parameter  int CONF_WIDTH = 5,
    localparam int SEL_WIDTH  = clog2_min1(NUM_SLAVES)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_en_s,
    input  logic [SEL_WIDTH-1:0]             i_sel,
    input  logic [DATA_WIDTH-1:0]            i_data_in,
    input  logic [CONF_WIDTH-1:0]            i_conf_dbus,
    input  logic                             i_write,
    input  logic                             i_read,
    input  logic                             i_start,
    output logic [DATA_WIDTH-1:0]            o_data_out,
    output logic                             o_rd_valid,
    output logic                             o_sel_err,
    input  logic                             i_mask_wr,
    input  logic [NUM_SLAVES-1:0]            i_mask_data,
    input  logic                             i_int_ack,
    output logic                             o_int_req,
    output logic [SEL_WIDTH-1:0]             o_int_id,
    output logic [NUM_SLAVES-1:0]            o_busy,
    output logic [NUM_SLAVES*DATA_WIDTH-1:0] o_data_s,
    output logic [NUM_SLAVES*CONF_WIDTH-1:0] o_conf_s,
    output logic [NUM_SLAVES-1:0]            o_write_s,
    output logic [NUM_SLAVES-1:0]            o_read_s,
    output logic [NUM_SLAVES-1:0]            o_start_s,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] i_data_s,
    input  logic [NUM_SLAVES-1:0]            i_int_s
);

    localparam logic [SEL_WIDTH:0] NUM_S = (SEL_WIDTH + 1)'(NUM_SLAVES);

    logic [STB_COUNT-1:0] stb;
    logic                 any_stb;
    logic                 in_range;
    logic                 accept;
    logic                 reject;

    logic                 rd_pend_q;
    logic                 rd_err_q;
    logic [SEL_WIDTH-1:0] rd_sel_q;

    // Decode the host command into accept, reject or ignore.
    always_comb begin
        stb            = '0;
        stb[STB_WRITE] = i_write;
        stb[STB_READ]  = i_read;
        stb[STB_START] = i_start;
        any_stb        = |stb;
        in_range       = {1'b0, i_sel} < NUM_S;
        accept         = i_en_s & any_stb & in_range;
        reject         = i_en_s & any_stb & ~in_range;
    end

    // Channel registers: strobes pulse for one cycle. Data and conf hold until the channel is next addressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_write_s <= '0;
            o_read_s  <= '0;
            o_start_s <= '0;
            o_data_s  <= '0;
            o_conf_s  <= '0;
            o_sel_err <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_err_q  <= 1'b0;
            rd_sel_q  <= '0;
        end else begin
            o_write_s <= '0;
            o_read_s  <= '0;
            o_start_s <= '0;
            o_sel_err <= reject;
            rd_pend_q <= (accept | reject) & stb[STB_READ];
            rd_err_q  <= reject & stb[STB_READ];
            if (accept) begin
                o_write_s[i_sel] <= stb[STB_WRITE];
                o_read_s[i_sel]  <= stb[STB_READ];
                o_start_s[i_sel] <= stb[STB_START];
                o_data_s[i_sel*DATA_WIDTH +: DATA_WIDTH] <= i_data_in;
                o_conf_s[i_sel*CONF_WIDTH +: CONF_WIDTH] <= i_conf_dbus;
                rd_sel_q <= i_sel;
            end
        end
    end

    // Read return: sample the addressed slave at the end of the strobe cycle. An out-of-range read returns zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_data_out <= '0;
            o_rd_valid <= 1'b0;
        end else begin
            o_rd_valid <= rd_pend_q;
            if (rd_pend_q) begin
                o_data_out <= rd_err_q ? '0 : i_data_s[rd_sel_q*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    aip_int_ctrl #(
        .NUM_SLAVES (NUM_SLAVES)
    ) u_int_ctrl (
        .clk       (clk),
        .rst       (rst),
        .int_s     (i_int_s),
        .start_fwd (o_start_s),
        .mask_wr   (i_mask_wr),
        .mask_data (i_mask_data),
        .int_ack   (i_int_ack),
        .int_req   (o_int_req),
        .int_id    (o_int_id),
        .busy      (o_busy)
    );

endmodule

// File: tb/tb_aip_slave_router_n.sv
// Directed bench for aip_slave_router_n with a read-data scoreboard.
module tb_aip_slave_router_n;

    localparam int NS = 3;
    localparam int DW = 32;
    localparam int CW = 5;
    localparam int SW = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             i_en_s = 1'b1;
    logic [SW-1:0]    i_sel = '0;
    logic [DW-1:0]    i_data_in = '0;
    logic [CW-1:0]    i_conf_dbus = '0;
    logic             i_write = 1'b0;
    logic             i_read = 1'b0;
    logic             i_start = 1'b0;
    logic [DW-1:0]    o_data_out;
    logic             o_rd_valid;
    logic             o_sel_err;
    logic             i_mask_wr = 1'b0;
    logic [NS-1:0]    i_mask_data = '0;
    logic             i_int_ack = 1'b0;
    logic             o_int_req;
    logic [SW-1:0]    o_int_id;
    logic [NS-1:0]    o_busy;
    logic [NS*DW-1:0] o_data_s;
    logic [NS*CW-1:0] o_conf_s;
    logic [NS-1:0]    o_write_s;
    logic [NS-1:0]    o_read_s;
    logic [NS-1:0]    o_start_s;
    logic [NS*DW-1:0] i_data_s;
    logic [NS-1:0]    i_int_s = '0;

    logic [DW-1:0] slave_data [NS];
    logic [DW-1:0] exp_q [$];
    int checks = 0;
    int failures = 0;

    assign i_data_s = {slave_data[2], slave_data[1], slave_data[0]};

    aip_slave_router_n #(
        .NUM_SLAVES (NS),
        .DATA_WIDTH (DW),
        .CONF_WIDTH (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_en_s      (i_en_s),
        .i_sel       (i_sel),
        .i_data_in   (i_data_in),
        .i_conf_dbus (i_conf_dbus),
        .i_write     (i_write),
        .i_read      (i_read),
        .i_start     (i_start),
        .o_data_out  (o_data_out),
        .o_rd_valid  (o_rd_valid),
        .o_sel_err   (o_sel_err),
        .i_mask_wr   (i_mask_wr),
        .i_mask_data (i_mask_data),
        .i_int_ack   (i_int_ack),
        .o_int_req   (o_int_req),
        .o_int_id    (o_int_id),
        .o_busy      (o_busy),
        .o_data_s    (o_data_s),
        .o_conf_s    (o_conf_s),
        .o_write_s   (o_write_s),
        .o_read_s    (o_read_s),
        .o_start_s   (o_start_s),
        .i_data_s    (i_data_s),
        .i_int_s     (i_int_s)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    // Scoreboard: every o_rd_valid pulse pops one expected read result
    always @(negedge clk) begin
        if (!rst && o_rd_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $error("FAIL rd_unexpected observed=%0h expected=none", o_data_out);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                assert (o_data_out === e) else begin
                    failures++;
                    $error("FAIL rd_data observed=%0h expected=%0h", o_data_out, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
    endtask

    // Drive one host command for a single cycle; returns in the cycle after acceptance
    task automatic cmd(input int sel, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic w, input logic r, input logic s);
        i_sel       = sel[SW-1:0];
        i_data_in   = d;
        i_conf_dbus = c;
        i_write     = w;
        i_read      = r;
        i_start     = s;
        if (r && i_en_s) exp_q.push_back(sel < NS ? slave_data[sel] : '0);
        step();
        i_write = 1'b0;
        i_read  = 1'b0;
        i_start = 1'b0;
    endtask

    task automatic ack();
        i_int_ack = 1'b1;
        step();
        i_int_ack = 1'b0;
    endtask

    initial begin
        slave_data[0] = 32'hA0A0_0000;
        slave_data[1] = 32'h1234_5678;
        slave_data[2] = 32'hCAFE_F00D;

        // Reset values
        do_reset();
        check("rst_write_s", o_write_s, 3'b000);
        check("rst_rd_valid", o_rd_valid, 1'b0);
        check("rst_sel_err", o_sel_err, 1'b0);
        check("rst_int_req", o_int_req, 1'b0);
        check("rst_int_id", o_int_id, 2'd0);
        check("rst_busy", o_busy, 3'b000);
        check("rst_data_s", o_data_s, 96'h0);
        check("rst_data_out", o_data_out, 32'h0);

        // Write to slave 2
        cmd(2, 32'hDEAD_BEEF, 5'h03, 1'b1, 1'b0, 1'b0);
        check("wr_write_s", o_write_s, 3'b100);
        check("wr_read_s", o_read_s, 3'b000);
        check("wr_data_s2", o_data_s[2*DW +: DW], 32'hDEAD_BEEF);
        check("wr_conf_s2", o_conf_s[2*CW +: CW], 5'h03);
        check("wr_data_s0", o_data_s[0*DW +: DW], 32'h0);
        check("wr_data_s1", o_data_s[1*DW +: DW], 32'h0);
        step();
        check("wr_pulse_end", o_write_s, 3'b000);
        check("wr_data_hold", o_data_s[2*DW +: DW], 32'hDEAD_BEEF);

        // Disabled command is ignored
        i_en_s = 1'b0;
        cmd(1, 32'h0000_0055, 5'h07, 1'b1, 1'b0, 1'b0);
        check("dis_write_s", o_write_s, 3'b000);
        check("dis_sel_err", o_sel_err, 1'b0);
        check("dis_data_s1", o_data_s[1*DW +: DW], 32'h0);
        i_en_s = 1'b1;

        // Single read from slave 1: latency 2
        cmd(1, 32'h0, 5'h00, 1'b0, 1'b1, 1'b0);
        check("rd_read_s", o_read_s, 3'b010);
        check("rd_valid_early", o_rd_valid, 1'b0);
        step();
        check("rd_valid", o_rd_valid, 1'b1);
        step();
        check("rd_valid_end", o_rd_valid, 1'b0);

        // Back-to-back reads 0,1,2,0
        cmd(0, 32'h0, 5'h00, 1'b0, 1'b1, 1'b0);
        cmd(1, 32'h0, 5'h00, 1'b0, 1'b1, 1'b0);
        check("b2b_valid_1", o_rd_valid, 1'b1);
        cmd(2, 32'h0, 5'h00, 1'b0, 1'b1, 1'b0);
        check("b2b_valid_2", o_rd_valid, 1'b1);
        cmd(0, 32'h0, 5'h00, 1'b0, 1'b1, 1'b0);
        check("b2b_valid_3", o_rd_valid, 1'b1);
        step();
        check("b2b_valid_4", o_rd_valid, 1'b1);
        step();
        check("b2b_done", o_rd_valid, 1'b0);

        // Out-of-range read
        cmd(3, 32'h0, 5'h00, 1'b0, 1'b1, 1'b0);
        check("oor_read_s", o_read_s, 3'b000);
        check("oor_sel_err", o_sel_err, 1'b1);
        step();
        check("oor_rd_valid", o_rd_valid, 1'b1);
        check("oor_sel_err_end", o_sel_err, 1'b0);
        step();

        // Write + start together to slave 0, busy follows one cycle later
        cmd(0, 32'h0000_1111, 5'h01, 1'b1, 1'b0, 1'b1);
        check("ws_write_s", o_write_s, 3'b001);
        check("ws_start_s", o_start_s, 3'b001);
        check("ws_busy_early", o_busy, 3'b000);
        step();
        check("ws_busy", o_busy, 3'b001);
        check("ws_start_end", o_start_s, 3'b000);

        // Reset mid-read drops the read
        cmd(1, 32'h0, 5'h00, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        check("rstrd_valid_a", o_rd_valid, 1'b0);
        step();
        check("rstrd_valid_b", o_rd_valid, 1'b0);
        check("rstrd_busy", o_busy, 3'b000);

        // Start slave 0, completion interrupt, ack, held level
        do_reset();
        cmd(0, 32'h0, 5'h00, 1'b0, 1'b0, 1'b1);
        step();
        check("irq_busy_set", o_busy, 3'b001);
        i_int_s = 3'b001;
        step();
        check("irq_busy_clr", o_busy, 3'b000);
        check("irq_req", o_int_req, 1'b1);
        check("irq_id", o_int_id, 2'd0);
        ack();
        check("irq_ack_req", o_int_req, 1'b0);
        step();
        step();
        check("irq_level_held", o_int_req, 1'b0);

        // Three simultaneous edges served 0,1,2; then 0 and 2 after wrap
        i_int_s = 3'b000;
        do_reset();
        i_int_s = 3'b111;
        step();
        check("rr_req_a", o_int_req, 1'b1);
        check("rr_id_a", o_int_id, 2'd0);
        ack();
        check("rr_id_b", o_int_id, 2'd1);
        ack();
        check("rr_id_c", o_int_id, 2'd2);
        ack();
        check("rr_req_done", o_int_req, 1'b0);
        i_int_s = 3'b000;
        step();
        i_int_s = 3'b101;
        step();
        check("rr_wrap_id", o_int_id, 2'd0);
        ack();
        check("rr_wrap_id2", o_int_id, 2'd2);
        check("rr_wrap_req2", o_int_req, 1'b1);
        ack();
        check("rr_wrap_done", o_int_req, 1'b0);

        // Masking, unmask, ack coincident with a new edge
        i_int_s = 3'b000;
        step();
        i_mask_wr   = 1'b1;
        i_mask_data = 3'b101;
        step();
        i_mask_wr = 1'b0;
        i_int_s = 3'b010;
        step();
        check("mask_req_a", o_int_req, 1'b0);
        step();
        check("mask_req_b", o_int_req, 1'b0);
        i_mask_wr   = 1'b1;
        i_mask_data = 3'b111;
        step();
        i_mask_wr = 1'b0;
        check("unmask_req", o_int_req, 1'b1);
        check("unmask_id", o_int_id, 2'd1);
        i_int_s = 3'b000;
        step();
        check("pre_coinc_req", o_int_req, 1'b1);
        i_int_s = 3'b010;
        ack();
        check("coinc_req", o_int_req, 1'b1);
        check("coinc_id", o_int_id, 2'd1);
        ack();
        check("coinc_clear", o_int_req, 1'b0);

        // All issued reads must have been returned
        check("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
